nibble_serial_add_ctrl: RTL
===========================

Name: nibble_serial_add_ctrl

Overview:
- Sequencer that computes wide add/subtract by driving one internal 4-bit ripple-carry nibble adder (with carry-in) for NIBBLES cycles, least-significant nibble first.
- A registered carry links consecutive nibbles.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area compared with a full-width adder.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand. Operand width W = 4*NIBBLES. Legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low. Sampled on the rising edge of clk.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept a new operation.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  W  sum or difference.
- carry_out  output  1  final carry. On subtract, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - result, carry_out and overflow are all 0.
  - Nibble index is 0, carry register is 0, operand registers are cleared.
  - Reset overrides every other input, including during RUN or DONE. Any in-flight operation is discarded and no out_valid pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on the edge where in_valid && in_ready.
  - On accept, latch op_a into a shift register.
  - Latch op_b into a shift register; store ~op_b instead when sub=1.
  - Set the carry register to sub.
  - Set idx=0 and go to RUN.
  - in_valid low: stay in IDLE.
- RUN:
  - in_ready=0.
  - Each edge: compute nibble {c,s} = a[3:0] + b[3:0] + carry_reg, 5-bit result.
  - Write s into result nibble idx. Set carry_reg = c.
  - Shift the operand registers right by 4 and increment idx.
  - On the edge where idx==NIBBLES-1, after the update above:
    - carry_out = c.
    - overflow = (a_msb == b_msb) && (s_msb != a_msb), using the msbs of the final nibble operands, with b already inverted for subtract.
    - Go to DONE.
  - in_valid is ignored during RUN.
- DONE:
  - out_valid=1.
  - result, carry_out and overflow are held stable while out_ready=0.
  - On the edge with out_ready=1: out_valid=0, go to IDLE.
  - in_ready stays 0 in DONE. No accept can occur on the same edge as the output handshake; the earliest next accept is one cycle later.
- Latency:
  - Accept edge E0. out_valid is high after edge E0+NIBBLES.
  - Minimum throughput is one operation per NIBBLES+2 cycles.
- Arithmetic:
  - Modulo 2^W.
  - Subtract computes A + ~B + 1.
  - carry_out on subtract is the inverted borrow.
- result is only guaranteed meaningful while out_valid=1. It is updated nibble-by-nibble during RUN.
- NIBBLES=1: RUN lasts exactly one edge.
- The index counter is wide enough for NIBBLES-1 and never wraps past it.

Test Plan (NIBBLES=4):
- Plain add: accept op_a=0x1234, op_b=0x4321, sub=0.
  - Required: out_valid high exactly 4 edges after accept; result=0x5555, carry_out=0, overflow=0.
  - in_ready is 0 from accept until one cycle after the output handshake.
- Carry ripple across nibbles: 0xFFFF+0x0001.
  - Required: result=0x0000, carry_out=1, overflow=0.
  - Signed overflow case: 0x7FFF+0x0001, required result=0x8000, carry_out=0, overflow=1.
- Subtract: 0x0007-0x0005.
  - Required: result=0x0002, carry_out=1.
  - Borrow case: 0x0005-0x0007, required result=0xFFFE, carry_out=0, overflow=0.
  - Signed overflow case: 0x8000-0x0001, required result=0x7FFF, overflow=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands.
  - Required: result/carry_out/overflow unchanged, out_valid=1, in_ready=0, new operands not accepted.
  - Raise out_ready: required IDLE next cycle, then the new operation is accepted.
- Reset mid-operation: assert rst_n=0 for one edge after the 2nd RUN edge.
  - Required: IDLE, in_ready=1, out_valid=0, result=0. No out_valid ever appears for the aborted operation.
  - The following 0x0001+0x0001 then yields result=0x0002.
- Back-to-back operations: 10 random operand pairs and modes, with out_ready=1 always.
  - Required: each result matches (A±B) mod 2^16 with correct carry and overflow flags.
  - Accept-to-accept spacing is exactly 6 cycles.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_if.sv
// Handshake bundle for nibble_serial_add_ctrl.
//   Producer side : in_valid/in_ready, op_a, op_b, sub
//   Consumer side : out_valid/out_ready, result, carry_out, overflow
//   Status        : busy
// The master modport is the producer/consumer environment.
// The slave modport is the sequencer itself.
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, busy
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract built from a single 4-bit adder with carry-in.
// The operation takes NIBBLES cycles, working from the least-significant
// nibble to the most-significant one.
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : slave side of nibble_serial_add_ctrl_if
//           - in_valid/in_ready with op_a, op_b, sub
//           - out_valid/out_ready with result, carry_out, overflow
//           - busy
// All outputs are registered.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry_reg;
    logic [IDXW-1:0] idx_reg;
    logic [W-1:0]    result_reg;
    logic            carry_out_reg;
    logic            overflow_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;
    logic            busy_reg;

    logic [4:0]      nib_sum;
    logic [W-1:0]    result_next;

    // The operand registers shift right by one nibble per cycle.
    // Bits [3:0] therefore always hold the current slice.
    always_comb begin
        nib_sum = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'b0000, carry_reg};
    end

    // Only the nibble selected by idx takes the new sum.
    // The other nibbles keep the values already written.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign result_next[gi*4 +: 4] = (idx_reg == IDXW'(gi)) ? nib_sum[3:0]
                                                                 : result_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        // Subtract is A + ~B + 1.
                        // The +1 enters through the first carry-in.
                        a_reg        <= bus.op_a;
                        b_reg        <= bus.sub ? ~bus.op_b : bus.op_b;
                        carry_reg    <= bus.sub;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    carry_reg  <= nib_sum[4];
                    a_reg      <= a_reg >> 4;
                    b_reg      <= b_reg >> 4;
                    if (idx_reg == LAST_IDX) begin
                        // a_reg[3] and b_reg[3] are now the sign bits of the full operands.
                        // b_reg has already been inverted for subtract.
                        carry_out_reg <= nib_sum[4];
                        overflow_reg  <= (a_reg[3] == b_reg[3]) && (nib_sum[3] != a_reg[3]);
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IDXW'(1);
                    end
                end
                DONE: begin
                    // in_ready remains low on the handshake edge.
                    // The next accept comes one cycle later, from IDLE.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.carry_out = carry_out_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.busy      = busy_reg;
endmodule
